// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
// Module : ifetch_pkg
// Brief  : Shared constants and state encodings for the fetch-stage sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package ifetch_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam logic [1:0]  ST_FETCH = 2'd0;
    localparam logic [1:0]  ST_HOLD  = 2'd1;
    localparam logic [1:0]  ST_DRAIN = 2'd2;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] PC_INC     = 32'd4;
    localparam logic [31:0] ALIGN_MASK = ~32'h3;

endpackage
`default_nettype wire

// File: rtl/ifetch_if.sv
`default_nettype none
// ============================================================================
// Module : ifetch_if
// Brief  : Instruction-memory request/acknowledge bundle between fetch and memory.
// Rev    : 1.0  initial release
// ============================================================================
interface ifetch_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/ifetch_skid.sv
`default_nettype none
// ============================================================================
// Module : ifetch_skid
// Brief  : One-entry instruction/npc buffer parking a fetch returned under stall.
// Rev    : 1.0  initial release
// ============================================================================
module ifetch_skid
    import ifetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            load,
    input  wire logic            drop,
    input  wire logic [XLEN-1:0] instr_in,
    input  wire logic [XLEN-1:0] npc_in,
    output logic      [XLEN-1:0] instr,
    output logic      [XLEN-1:0] npc,
    output logic                 valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr <= NOP_INSTR;
            npc   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            instr <= instr_in;
            npc   <= npc_in;
            valid <= 1'b1;
        end else if (drop) begin
            valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ifetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module : ifetch_ctrl
// Brief  : Fetch-stage PC owner, imem handshake FSM and IF/ID register loader.
//          Optional IFETCH_PERF_CNT_EN adds saturating fetch/stall/flush counters.
// Rev    : 1.0  initial release
// ============================================================================
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            EX_MEM_PCSrc,
    input  wire logic [XLEN-1:0] EX_MEM_NPC,
    input  wire logic            hazard_stall,
    ifetch_if.master             imem,
    output logic      [XLEN-1:0] pc,
    output logic      [XLEN-1:0] IF_ID_instr,
    output logic      [XLEN-1:0] IF_ID_npc,
`ifdef IFETCH_PERF_CNT_EN
    output logic      [31:0]     perf_fetch_cnt,
    output logic      [31:0]     perf_stall_cnt,
    output logic      [31:0]     perf_flush_cnt,
`endif
    output logic                 IF_ID_valid
);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_redir_pc;
    logic [XLEN-1:0] r_ifid_instr;
    logic [XLEN-1:0] r_ifid_npc;
    logic            r_ifid_valid;

    logic            w_req;
    logic            w_ack;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_pc_inc;
    logic            w_skid_load;
    logic            w_skid_drop;
    logic [XLEN-1:0] w_skid_instr;
    logic [XLEN-1:0] w_skid_npc;
    logic            w_skid_valid;

    // Address is r_pc in both FETCH and DRAIN; DRAIN never moves r_pc until the ack.
    assign w_req    = (r_state != ST_HOLD) && !rst;
    assign w_ack    = imem.imem_ack && w_req;
    assign w_target = EX_MEM_NPC & ALIGN_MASK;
    assign w_pc_inc = r_pc + PC_INC;

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pc;

    assign pc          = r_pc;
    assign IF_ID_instr = r_ifid_instr;
    assign IF_ID_npc   = r_ifid_npc;
    assign IF_ID_valid = r_ifid_valid;

    assign w_skid_load = (r_state == ST_FETCH) && w_ack && !EX_MEM_PCSrc && hazard_stall;
    assign w_skid_drop = (r_state == ST_HOLD) && (EX_MEM_PCSrc || !hazard_stall);

    ifetch_skid #(
        .XLEN (XLEN)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (w_skid_load),
        .drop     (w_skid_drop),
        .instr_in (imem.imem_rdata),
        .npc_in   (w_pc_inc),
        .instr    (w_skid_instr),
        .npc      (w_skid_npc),
        .valid    (w_skid_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_FETCH;
            r_pc         <= RESET_PC;
            r_redir_pc   <= RESET_PC;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_npc   <= '0;
            r_ifid_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (EX_MEM_PCSrc) begin
                        r_ifid_valid <= 1'b0;
                        if (w_ack) begin
                            r_pc <= w_target;
                        end else begin
                            r_redir_pc <= w_target;
                            r_state    <= ST_DRAIN;
                        end
                    end else if (w_ack) begin
                        r_pc <= w_pc_inc;
                        if (hazard_stall) begin
                            r_state <= ST_HOLD;
                        end else begin
                            r_ifid_instr <= imem.imem_rdata;
                            r_ifid_npc   <= w_pc_inc;
                            r_ifid_valid <= 1'b1;
                        end
                    end else if (!hazard_stall) begin
                        r_ifid_valid <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (EX_MEM_PCSrc) begin
                        r_pc         <= w_target;
                        r_ifid_valid <= 1'b0;
                        r_state      <= ST_FETCH;
                    end else if (!hazard_stall) begin
                        r_ifid_instr <= w_skid_instr;
                        r_ifid_npc   <= w_skid_npc;
                        r_ifid_valid <= w_skid_valid;
                        r_state      <= ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    r_ifid_valid <= 1'b0;
                    // A redirect arriving with the drain ack is the youngest target.
                    if (w_ack) begin
                        r_pc    <= EX_MEM_PCSrc ? w_target : r_redir_pc;
                        r_state <= ST_FETCH;
                    end else if (EX_MEM_PCSrc) begin
                        r_redir_pc <= w_target;
                    end
                end
                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    logic w_fetch_hit;

    assign w_fetch_hit = (r_state == ST_FETCH) && w_ack && !EX_MEM_PCSrc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (w_fetch_hit && (perf_fetch_cnt != '1)) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (hazard_stall && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (EX_MEM_PCSrc && (perf_flush_cnt != '1)) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_ifetch_ctrl
// Brief  : Directed self-checking bench for ifetch_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ifetch_ctrl;

    logic        clk;
    logic        rst;
    logic        EX_MEM_PCSrc;
    logic [31:0] EX_MEM_NPC;
    logic        hazard_stall;
    logic [31:0] pc;
    logic [31:0] IF_ID_instr;
    logic [31:0] IF_ID_npc;
    logic        IF_ID_valid;

    logic        zw;
    logic        ack_drv;
    logic [31:0] rdata_drv;

    int total;
    int bad;

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    ifetch_if #(.XLEN(32)) imem ();

    // Zero-wait mode answers every request with an address-derived word.
    assign imem.imem_ack   = zw ? imem.imem_req : ack_drv;
    assign imem.imem_rdata = zw ? (imem.imem_addr ^ 32'hA5A5_0000) : rdata_drv;

    ifetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .XLEN     (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .EX_MEM_PCSrc   (EX_MEM_PCSrc),
        .EX_MEM_NPC     (EX_MEM_NPC),
        .hazard_stall   (hazard_stall),
        .imem           (imem.master),
        .pc             (pc),
        .IF_ID_instr    (IF_ID_instr),
        .IF_ID_npc      (IF_ID_npc),
`ifdef IFETCH_PERF_CNT_EN
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt),
`endif
        .IF_ID_valid    (IF_ID_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; EX_MEM_PCSrc = 1'b0; EX_MEM_NPC = '0; hazard_stall = 1'b0;
        zw = 1'b1; ack_drv = 1'b0; rdata_drv = '0;
        @(negedge clk);
        chk("rst_req",   {31'd0, imem.imem_req}, 32'd0);
        chk("rst_pc",    pc, 32'h0);
        chk("rst_valid", {31'd0, IF_ID_valid}, 32'd0);
        chk("rst_instr", IF_ID_instr, 32'h0);
        chk("rst_npc",   IF_ID_npc, 32'h0);

        // Zero-wait memory: one instruction per cycle
        rst = 1'b0; #1;
        chk("zw_addr0", imem.imem_addr, 32'h0);
        chk("zw_req0",  {31'd0, imem.imem_req}, 32'd1);
        step();
        chk("zw_addr1",  imem.imem_addr, 32'h4);
        chk("zw_npc1",   IF_ID_npc, 32'h4);
        chk("zw_valid1", {31'd0, IF_ID_valid}, 32'd1);
        chk("zw_instr1", IF_ID_instr, 32'hA5A5_0000);
        step();
        chk("zw_addr2", imem.imem_addr, 32'h8);
        chk("zw_npc2",  IF_ID_npc, 32'h8);
        step();
        chk("zw_addr3",  imem.imem_addr, 32'hC);
        chk("zw_npc3",   IF_ID_npc, 32'hC);
        chk("zw_instr3", IF_ID_instr, 32'hA5A5_0008);

        // Two wait states
        rst = 1'b1; zw = 1'b0; ack_drv = 1'b0;
        step();
        rst = 1'b0; #1;
        chk("w2_addr_a", imem.imem_addr, 32'h0);
        step();
        chk("w2_addr_b",  imem.imem_addr, 32'h0);
        chk("w2_valid_b", {31'd0, IF_ID_valid}, 32'd0);
        chk("w2_pc_b",    pc, 32'h0);
        step();
        chk("w2_addr_c",  imem.imem_addr, 32'h0);
        chk("w2_valid_c", {31'd0, IF_ID_valid}, 32'd0);
        ack_drv = 1'b1; rdata_drv = 32'h1111_1111;
        step();
        chk("w2_pc",    pc, 32'h4);
        chk("w2_valid", {31'd0, IF_ID_valid}, 32'd1);
        chk("w2_instr", IF_ID_instr, 32'h1111_1111);
        chk("w2_npc",   IF_ID_npc, 32'h4);

        // Hazard stall during the ack of address 8
        rdata_drv = 32'h2222_2222;
        step();
        chk("st_npc_pre", IF_ID_npc, 32'h8);
        rdata_drv = 32'hDEAD_BEEF; hazard_stall = 1'b1;
        step();
        chk("st_req_hold",   {31'd0, imem.imem_req}, 32'd0);
        chk("st_instr_hold", IF_ID_instr, 32'h2222_2222);
        chk("st_npc_hold",   IF_ID_npc, 32'h8);
        chk("st_pc_hold",    pc, 32'hC);
        ack_drv = 1'b0;
        step();
        chk("st_instr_hold2", IF_ID_instr, 32'h2222_2222);
        hazard_stall = 1'b0;
        step();
        chk("st_rel_instr", IF_ID_instr, 32'hDEAD_BEEF);
        chk("st_rel_npc",   IF_ID_npc, 32'hC);
        chk("st_rel_valid", {31'd0, IF_ID_valid}, 32'd1);
        chk("st_rel_addr",  imem.imem_addr, 32'hC);

        // Redirect while a request to 0x10 is outstanding
        ack_drv = 1'b1; rdata_drv = 32'h3333_3333;
        step();
        chk("dr_addr_pre", imem.imem_addr, 32'h10);
        ack_drv = 1'b0; EX_MEM_PCSrc = 1'b1; EX_MEM_NPC = 32'h0000_0103;
        step();
        chk("dr_addr_a",  imem.imem_addr, 32'h10);
        chk("dr_req_a",   {31'd0, imem.imem_req}, 32'd1);
        chk("dr_valid_a", {31'd0, IF_ID_valid}, 32'd0);
        EX_MEM_PCSrc = 1'b0;
        step();
        chk("dr_addr_b",  imem.imem_addr, 32'h10);
        chk("dr_valid_b", {31'd0, IF_ID_valid}, 32'd0);
        ack_drv = 1'b1; rdata_drv = 32'h0000_0BAD;
        step();
        chk("dr_addr_tgt", imem.imem_addr, 32'h100);
        chk("dr_valid_c",  {31'd0, IF_ID_valid}, 32'd0);
        chk("dr_instr",    IF_ID_instr, 32'h3333_3333);

        // Redirect plus stall while holding a skid entry
        rdata_drv = 32'h4444_4444; hazard_stall = 1'b1;
        step();
        chk("hr_req_hold", {31'd0, imem.imem_req}, 32'd0);
        ack_drv = 1'b0; EX_MEM_PCSrc = 1'b1; EX_MEM_NPC = 32'h0000_0200;
        step();
        chk("hr_addr",  imem.imem_addr, 32'h200);
        chk("hr_req",   {31'd0, imem.imem_req}, 32'd1);
        chk("hr_valid", {31'd0, IF_ID_valid}, 32'd0);
        hazard_stall = 1'b0; EX_MEM_PCSrc = 1'b0; ack_drv = 1'b1; rdata_drv = 32'h5555_5555;
        step();
        chk("hr_instr", IF_ID_instr, 32'h5555_5555);
        chk("hr_npc",   IF_ID_npc, 32'h204);

        // Redirect coincident with ack in FETCH, aimed at the top of memory
        rdata_drv = 32'h6666_6666; EX_MEM_PCSrc = 1'b1; EX_MEM_NPC = 32'hFFFF_FFFC;
        step();
        chk("ra_addr",  imem.imem_addr, 32'hFFFF_FFFC);
        chk("ra_valid", {31'd0, IF_ID_valid}, 32'd0);
        chk("ra_instr", IF_ID_instr, 32'h5555_5555);

        // PC wrap
        EX_MEM_PCSrc = 1'b0; rdata_drv = 32'h7777_7777;
        step();
        chk("wr_addr",  imem.imem_addr, 32'h0);
        chk("wr_npc",   IF_ID_npc, 32'h0);
        chk("wr_instr", IF_ID_instr, 32'h7777_7777);

        // No ack: stall holds IF/ID, no stall inserts a bubble
        ack_drv = 1'b0; hazard_stall = 1'b1;
        step();
        chk("na_valid_stall", {31'd0, IF_ID_valid}, 32'd1);
        hazard_stall = 1'b0;
        step();
        chk("na_valid_bub", {31'd0, IF_ID_valid}, 32'd0);

        // Asynchronous reset mid-wait
        ack_drv = 1'b1; rdata_drv = 32'h8888_8888;
        step();
        chk("mr_pc_pre", pc, 32'h4);
        ack_drv = 1'b0; hazard_stall = 1'b1;
        step();
        chk("mr_valid_pre", {31'd0, IF_ID_valid}, 32'd1);
        rst = 1'b1; #1;
        chk("mr_pc",    pc, 32'h0);
        chk("mr_valid", {31'd0, IF_ID_valid}, 32'd0);
        chk("mr_instr", IF_ID_instr, 32'h0);
        chk("mr_npc",   IF_ID_npc, 32'h0);
        chk("mr_req",   {31'd0, imem.imem_req}, 32'd0);
        ack_drv = 1'b1; hazard_stall = 1'b0;
        step();
        chk("mr_late_pc", pc, 32'h0);
        rst = 1'b0; ack_drv = 1'b0; #1;
        chk("mr_rel_addr", imem.imem_addr, 32'h0);
        chk("mr_rel_req",  {31'd0, imem.imem_req}, 32'd1);
        step();
        chk("mr_rel_valid", {31'd0, IF_ID_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
Fetch-stage sequencer for the 5-stage pipeline. Owns the PC and drives a multi-cycle instruction-memory handshake. Applies branch redirects (EX_MEM_PCSrc / EX_MEM_NPC) and ID-stage hazard stalls, and loads the IF/ID pipeline register (IF_ID_instr, IF_ID_npc, IF_ID_valid) consumed by the decode stage.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
XLEN, 32, address/instruction width

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-high reset
EX_MEM_PCSrc  in  1  branch/jump taken; redirect this cycle
EX_MEM_NPC  in  XLEN  redirect target; bits [1:0] ignored, forced to 2'b00
hazard_stall  in  1  ID hazard unit: hold IF/ID contents
imem_req  out  1  fetch request valid
imem_addr  out  XLEN  fetch address (current PC)
imem_ack  in  1  memory returns imem_rdata this cycle
imem_rdata  in  XLEN  fetched instruction
pc  out  XLEN  architectural fetch PC
IF_ID_instr  out  XLEN  IF/ID instruction
IF_ID_npc  out  XLEN  IF/ID PC+4
IF_ID_valid  out  1  IF/ID holds a live instruction

Behaviour:
- Reset (async, rst=1): pc=RESET_PC; state=FETCH; imem_req=0 while rst high; IF_ID_instr=32'h0 (NOP); IF_ID_npc=0; IF_ID_valid=0; skid buffer empty.
- States: FETCH, HOLD, DRAIN.
- Handshake rule: once imem_req=1, imem_addr stays stable until the imem_ack cycle inclusive. imem_ack in the same cycle as req is legal (zero-wait memory). imem_ack with imem_req=0 is ignored.
- FETCH: imem_req=1, imem_addr=pc.
  - ack, no redirect, no stall: IF_ID_instr<=imem_rdata; IF_ID_npc<=pc+4; IF_ID_valid<=1; pc<=pc+4; stay FETCH. Zero-wait memory sustains 1 instr/cycle.
  - ack, no redirect, hazard_stall=1: rdata into skid buffer; pc<=pc+4; go HOLD. IF/ID unchanged.
  - no ack, no redirect: if hazard_stall=0, IF_ID_valid<=0 (bubble); if 1, IF/ID holds.
  - redirect with ack the same cycle: discard rdata; pc<=target; IF_ID_valid<=0; stay FETCH.
  - redirect without ack: latch target into redir_pc; IF_ID_valid<=0; go DRAIN.
- HOLD: imem_req=0.
  - hazard_stall=0: IF/ID<=skid contents, valid=1; go FETCH.
  - redirect (priority over everything): drop skid; pc<=target; IF_ID_valid<=0; go FETCH.
- DRAIN: imem_req=1, imem_addr=old pc, held stable.
  - On ack: discard data; pc<=redir_pc; go FETCH.
  - A further redirect in DRAIN overwrites redir_pc (youngest wins).
  - IF_ID_valid stays 0.
- Priority: redirect > hazard_stall > normal advance. A flush always clears IF_ID_valid the next cycle, even under stall.
- Arithmetic: pc+4 is modulo 2^XLEN; 32'hFFFF_FFFC+4 wraps to 0.
- Latency: ack in cycle N makes IF/ID visible at cycle N+1. Redirect in cycle N puts imem_addr=target at cycle N+1, or the cycle after the outstanding ack.
- Reset mid-operation: outstanding request abandoned; any late ack after reset while req=0 is ignored.

Optional Feature:
IFETCH_PERF_CNT_EN
- Defined: adds outputs perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt (32 bits each, reset 0, saturating at all-ones).
  - fetch: increments on each accepted (non-discarded) ack.
  - stall: increments each cycle hazard_stall=1.
  - flush: increments each cycle EX_MEM_PCSrc=1.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package ifetch_pkg: state enum (FETCH/HOLD/DRAIN), NOP_INSTR=32'h0, PC_INC=4, ALIGN_MASK=~32'h3.
- Sub-module ifetch_skid: a one-entry instruction/npc buffer with load/drop/valid.
- FSM and PC stay in ifetch_ctrl.

Test Plan:
- Reset, zero-wait memory (ack=req), RESET_PC=0: imem_addr 0,4,8,C on consecutive cycles; IF_ID_npc 4,8,C one cycle later, valid=1.
- 2-wait-state memory: imem_addr=0 held 3 cycles; IF_ID_valid pulses 0,0,1 pattern; pc=4 only after ack.
- hazard_stall=1 during ack of addr 8 (rdata 32'hDEAD_BEEF): IF/ID holds previous; release gives IF_ID_instr=DEADBEEF, npc=C; no refetch of 8.
- EX_MEM_PCSrc=1, EX_MEM_NPC=32'h0000_0103 while request to 0x10 outstanding: ack data discarded; next imem_addr=0x100; IF_ID_valid=0 through drain.
- Redirect and hazard_stall same cycle in HOLD: skid dropped; imem_addr=target next cycle; IF_ID_valid=0.
- pc=32'hFFFF_FFFC, ack: next imem_addr=0, IF_ID_npc=0. Assert rst mid-wait: outputs return to reset values immediately.
